// File: rtl/iir_biquad_sequencer.sv
// iir_biquad_sequencer: NSEC cascaded biquads time-shared on one multiplier, 6 cycles per section.
// Define IIR_SEQ_SATURATE_EN to clamp each section result (and report sat); otherwise results wrap.
module iir_biquad_sequencer #(
  parameter int N    = 16,
  parameter int NSEC = 4,
  parameter int FRAC = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [N-1:0] X,
  input  logic                coef_we,
  input  logic [4:0]          coef_addr,
  input  logic signed [N-1:0] coef_wdata,
  output logic                coef_err,
  output logic                out_valid,
  output logic signed [N-1:0] Y,
  output logic                sat
);
  localparam int NC = 5 * NSEC;
  localparam int AW = 2 * N + 4;
  localparam int SW = NSEC > 1 ? $clog2(NSEC) : 1;
  localparam logic signed [N-1:0] ONE = N'(1 << FRAC);
  typedef enum logic [1:0] {IDLE, MAC, UPD, DONE} state_t;
  state_t state, nstate;
  logic signed [N-1:0] coef [NC];
  logic signed [N-1:0] x1 [NSEC];
  logic signed [N-1:0] x2 [NSEC];
  logic signed [N-1:0] y1 [NSEC];
  logic signed [N-1:0] y2 [NSEC];
  logic signed [N-1:0] xc, opd, res;
  logic signed [2*N-1:0] prod;
  logic signed [AW-1:0] acc, pext;
  logic [SW-1:0] s;
  logic [2:0] k;
  logic [4:0] idx;
  logic clip, sat_acc, wr_ok;
`ifdef IIR_SEQ_SATURATE_EN
  localparam logic signed [AW-1:0] MAXV = AW'((1 << (N - 1)) - 1);
  localparam logic signed [AW-1:0] MINV = ~MAXV;
  logic signed [AW-1:0] sh;
`endif
  always_comb begin
    nstate = state;
    nstate = state == IDLE ? (in_valid ? MAC : IDLE)
           : state == MAC  ? (k == 3'd4 ? UPD : MAC)
           : state == UPD  ? (s == SW'(NSEC - 1) ? DONE : MAC)
           : IDLE;
    in_ready = state == IDLE;
    wr_ok = coef_we && state == IDLE && int'(coef_addr) < NC;
    idx = 5'(int'(s) * 5 + int'(k));
    opd = k == 3'd0 ? xc : k == 3'd1 ? x1[s] : k == 3'd2 ? x2[s] : k == 3'd3 ? y1[s] : y2[s];
    prod = coef[idx] * opd;
    pext = AW'(prod);
`ifdef IIR_SEQ_SATURATE_EN
    sh = acc >>> FRAC;
    clip = sh > MAXV || sh < MINV;
    res = sh > MAXV ? MAXV[N-1:0] : sh < MINV ? MINV[N-1:0] : sh[N-1:0];
`else
    res = acc[FRAC +: N];
    clip = 1'b0;
`endif
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nstate;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NC; i++) coef[i] <= (i % 5 == 0) ? ONE : '0;
      for (int i = 0; i < NSEC; i++) begin
        x1[i] <= '0;
        x2[i] <= '0;
        y1[i] <= '0;
        y2[i] <= '0;
      end
      xc <= '0;
      acc <= '0;
      s <= '0;
      k <= '0;
      sat_acc <= 1'b0;
      Y <= '0;
      sat <= 1'b0;
      out_valid <= 1'b0;
      coef_err <= 1'b0;
    end else begin
      out_valid <= state == DONE;
      coef_err <= coef_we && !wr_ok;
      if (wr_ok) coef[coef_addr] <= coef_wdata;
      if (state == IDLE && in_valid) begin
        xc <= X;
        s <= '0;
        k <= '0;
        acc <= '0;
        sat_acc <= 1'b0;
      end
      // b1/b2 products (k=3,4) are subtracted
      if (state == MAC) begin
        acc <= k >= 3'd3 ? acc - pext : acc + pext;
        k <= k + 3'd1;
      end
      if (state == UPD) begin
        x2[s] <= x1[s];
        x1[s] <= xc;
        y2[s] <= y1[s];
        y1[s] <= res;
        xc <= res;
        acc <= '0;
        k <= '0;
        s <= s + 1'b1;
        sat_acc <= sat_acc | clip;
      end
      if (state == DONE) begin
        Y <= xc;
        sat <= sat_acc;
      end
    end
  end
endmodule

// File: tb/tb_iir_biquad_sequencer.sv
// tb_iir_biquad_sequencer: directed vectors with hand-computed results for the 4-section default build.
module tb_iir_biquad_sequencer;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, coef_we = 1'b0;
  logic in_ready, coef_err, out_valid, sat;
  logic [15:0] X = '0, coef_wdata = '0, Y;
  logic [4:0] coef_addr = '0;
  int n_cmp = 0, n_err = 0;
  int n;
  logic seen;
  iir_biquad_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .X(X),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .coef_err(coef_err), .out_valid(out_valid), .Y(Y), .sat(sat)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
  endtask
  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    @(negedge clk);
    coef_we = 1'b1;
    coef_addr = a;
    coef_wdata = d;
    @(posedge clk);
    #1 coef_we = 1'b0;
  endtask
  task automatic start(input logic [15:0] x);
    @(negedge clk);
    X = x;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic wait_out(output int cnt);
    cnt = 0;
    while (!out_valid && cnt < 60) begin
      @(posedge clk);
      #1 cnt++;
    end
  endtask
  task automatic sample(input string tag, input logic [15:0] x, input logic [15:0] ey, input logic es);
    int c;
    start(x);
    chk({tag, "_busy"}, in_ready, 1'b0);
    wait_out(c);
    chk({tag, "_lat"}, c, 25);
    chk({tag, "_y"}, Y, ey);
    chk({tag, "_sat"}, sat, es);
    @(posedge clk);
    #1 chk({tag, "_pulse"}, out_valid, 1'b0);
  endtask
  initial begin
    do_reset();
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_err", coef_err, 1'b0);
    chk("rst_y", Y, 16'h0000);
    chk("rst_sat", sat, 1'b0);
    sample("pass", 16'h1234, 16'h1234, 1'b0);
    do_reset();
    wr(5'd0, 16'h2000);
    chk("wr_ok_err", coef_err, 1'b0);
    sample("half", 16'h4000, 16'h2000, 1'b0);
    do_reset();
    wr(5'd0, 16'h0000);
    wr(5'd1, 16'h4000);
    sample("dly0", 16'd100, 16'd0, 1'b0);
    sample("dly1", 16'd200, 16'd100, 1'b0);
    do_reset();
    wr(5'd3, 16'hE000);
    sample("fb0", 16'h1000, 16'h1000, 1'b0);
    sample("fb1", 16'h0000, 16'h0800, 1'b0);
    sample("fb2", 16'h0000, 16'h0400, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) wr(5'(i * 5), 16'h7FFF);
`ifdef IIR_SEQ_SATURATE_EN
    sample("big", 16'h4000, 16'h7FFF, 1'b1);
`else
    sample("big", 16'h4000, 16'hFFF0, 1'b0);
`endif
    do_reset();
    wr(5'd20, 16'h1111);
    chk("bad_addr_err", coef_err, 1'b1);
    @(posedge clk);
    #1 chk("bad_addr_err_clr", coef_err, 1'b0);
    start(16'h1234);
    wr(5'd0, 16'h0000);
    chk("busy_wr_err", coef_err, 1'b1);
    wait_out(n);
    chk("busy_wr_y", Y, 16'h1234);
    sample("busy_wr_keep", 16'h0100, 16'h0100, 1'b0);
    do_reset();
    @(negedge clk);
    coef_we = 1'b1;
    coef_addr = 5'd0;
    coef_wdata = 16'h2000;
    X = 16'h4000;
    in_valid = 1'b1;
    @(posedge clk);
    #1 begin
      coef_we = 1'b0;
      in_valid = 1'b0;
    end
    wait_out(n);
    chk("same_edge_lat", n, 25);
    chk("same_edge_y", Y, 16'h2000);
    start(16'h0777);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("mid_rst_valid", out_valid, 1'b0);
    @(negedge clk) rst = 1'b0;
    chk("mid_rst_ready", in_ready, 1'b1);
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1 seen |= out_valid;
    end
    chk("mid_rst_no_out", seen, 1'b0);
    sample("mid_rst_pass", 16'h0777, 16'h0777, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
